voter_plus: RTL and testbench

- Weighted, latching vote counter with three voter classes.
  - 32 normal voters: weight 1.
  - 8 VIP voters: weight 4.
  - 1 VVIP voter: weight 16.
- A voter's vote is latched on the first clock edge where its input bit is high. It stays counted until reset; votes cannot be withdrawn.
- Output is the running weighted total. The block is a small standalone datapath used as a voting/tally unit.

---
 rtl/voter_plus.sv | 68 ++++++
 tb/tb_voter_plus.sv | 79 +++++++
 2 files changed

// File: rtl/voter_plus.sv
// Weighted, latching vote tally: 32 normal voters (weight 1), 8 VIPs (weight 4)
// and one VVIP (weight 16). Each voter is counted once until reset.
module voter_plus (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] np,
    input  logic [7:0]  vip,
    input  logic        vvip,
    output logic [7:0]  result
);

    logic [31:0] np_q,   np_d;
    logic [7:0]  vip_q,  vip_d;
    logic        vvip_q, vvip_d;

    // Flags only ever accumulate; a ballot dropping back to 0 leaves its flag set.
    always_comb begin
        np_d   = np_q | np;
        vip_d  = vip_q | vip;
        vvip_d = vvip_q | vvip;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            np_q   <= '0;
            vip_q  <= '0;
            vvip_q <= 1'b0;
        end else begin
            np_q   <= np_d;
            vip_q  <= vip_d;
            vvip_q <= vvip_d;
        end
    end

    // Per-bit zero-extended terms summed as an adder chain.
    logic [5:0] np_terms  [32];
    logic [3:0] vip_terms [8];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_np_term
            assign np_terms[gi] = {5'd0, np_q[gi]};
        end
        for (gi = 0; gi < 8; gi++) begin : g_vip_term
            assign vip_terms[gi] = {3'd0, vip_q[gi]};
        end
    endgenerate

    logic [5:0] np_count;
    logic [3:0] vip_count;
    logic [6:0] total;

    always_comb begin
        np_count = '0;
        for (int i = 0; i < 32; i++) begin
            np_count = np_count + np_terms[i];
        end
        vip_count = '0;
        for (int j = 0; j < 8; j++) begin
            vip_count = vip_count + vip_terms[j];
        end
        // Max 32 + 32 + 16 = 80, so 7 bits never overflow.
        total = {1'b0, np_count} + {1'b0, vip_count, 2'b00} + {2'b00, vvip_q, 4'b0000};
    end

    assign result = {1'b0, total};

endmodule

// File: tb/tb_voter_plus.sv
// Directed-vector bench for voter_plus; expected totals are hand-computed
// weighted sums of the flags latched so far.
module tb_voter_plus;

    logic        clk;
    logic        reset;
    logic [31:0] np;
    logic [7:0]  vip;
    logic        vvip;
    logic [7:0]  result;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    voter_plus dut (
        .clk    (clk),
        .reset  (reset),
        .np     (np),
        .vip    (vip),
        .vvip   (vvip),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s: result=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: result=%0d", tag, got);
        end
    endtask

    // Apply one set of inputs across a rising edge, then check the total just after it.
    task automatic step(input string tag, input logic r, input logic [31:0] n,
                        input logic [7:0] v, input logic vv, input logic [7:0] exp);
        reset = r;
        np    = n;
        vip   = v;
        vvip  = vv;
        @(posedge clk);
        #1;
        check_val(tag, result, exp);
    endtask

    initial begin
        reset = 1'b1;
        np    = '0;
        vip   = '0;
        vvip  = 1'b0;

        step("reset_edge0",      1'b1, 32'hDEAD_BEEF, 8'hFF, 1'b1, 8'd0);
        step("reset_edge1",      1'b1, 32'h1234_5678, 8'hA5, 1'b1, 8'd0);
        step("first_ballots",    1'b0, 32'h0000_00FC, 8'h5A, 1'b1, 8'd38);
        step("subset_no_double", 1'b0, 32'h0000_00F0, 8'h0A, 1'b0, 8'd38);
        step("new_bits",         1'b0, 32'h0000_0103, 8'h01, 1'b0, 8'd45);
        step("idle_after_new",   1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'd45);
        step("all_high",         1'b0, 32'hFFFF_FFFF, 8'hFF, 1'b1, 8'd80);
        step("hold80_a",         1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'd80);
        step("hold80_b",         1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'd80);
        step("hold80_c",         1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'd80);
        step("hold80_reassert",  1'b0, 32'hFFFF_FFFF, 8'hFF, 1'b1, 8'd80);
        step("mid_reset",        1'b1, 32'hFFFF_FFFF, 8'h00, 1'b0, 8'd0);
        step("post_reset_np1",   1'b0, 32'h0000_0001, 8'h00, 1'b0, 8'd1);
        step("reset_with_vote",  1'b1, 32'h0000_0001, 8'h80, 1'b1, 8'd0);
        step("dropped_at_reset", 1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'd0);
        step("vvip_only",        1'b0, 32'h0000_0000, 8'h00, 1'b1, 8'd16);
        step("vip_msb",          1'b0, 32'h0000_0000, 8'h80, 1'b0, 8'd20);
        step("np_msb",           1'b0, 32'h8000_0000, 8'h00, 1'b0, 8'd21);
        step("np_mixed",         1'b0, 32'h0F00_0000, 8'h24, 1'b0, 8'd33);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
